// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS data-memory stage.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } sb_state_t;

    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/store_fifo.sv
// Circular buffer of posted stores with a youngest-match search port for forwarding.
module store_fifo
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [ADDR_W-1:WORD_LSB]   search_word,
    output logic                       hit,
    output logic [DATA_W-1:0]          hit_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx][ADDR_W-1:WORD_LSB] == search_word)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Data-memory stage: posts stores into a FIFO, forwards loads, and stalls the core on load misses.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_we,
    input  logic                    cpu_re,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [$clog2(DEPTH):0]  sb_count,
    output logic                    sb_empty
);

    sb_state_t         state, next_state;
    logic              full, push, pop, hit, ack, load_miss;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data, hit_data, rdata_q;

    store_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (cpu_addr),
        .push_data   (cpu_wdata),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (sb_count),
        .full        (full),
        .empty       (sb_empty),
        .search_word (cpu_addr[ADDR_W-1:WORD_LSB]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    assign ack       = mem_ack && mem_req;
    assign load_miss = cpu_re && !hit && (state != RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_miss)      next_state = READ;
                else if (!sb_empty) next_state = WRITE;
            end
            WRITE:   if (ack) next_state = IDLE;
            READ:    if (ack) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push      = cpu_we && !full;
        pop       = (state == WRITE) && ack;
        cpu_stall = (cpu_we && full) || load_miss;
        cpu_rdata = ((state == RESP) || !hit) ? rdata_q : hit_data;
    end

    // Bus fields load only on leaving IDLE, so they stay stable until the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            mem_req <= (next_state == WRITE) || (next_state == READ);
            mem_we  <= (next_state == WRITE);
            if (state == IDLE && next_state == WRITE) begin
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
            end
            if (state == IDLE && next_state == READ) mem_addr <= cpu_addr;
            if (state == READ && ack)                rdata_q  <= mem_rdata;
        end
    end

    a_no_we_and_re: assert property (@(posedge clk) disable iff (!reset) !(cpu_we && cpu_re));

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a bus responder pops expected transactions as it acks them.
module tb_store_buffer;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk, reset;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    txn_t        exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int unsigned latency  = 2;
    bit          hold_ack = 0;
    int unsigned peak     = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sb_count  (sb_count),
        .sb_empty  (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    // Bus responder: acks on the latency-th cycle of a request unless held.
    initial begin : responder
        int unsigned req_cycles;
        bit          gap_pending;
        logic [31:0] cur_addr;
        logic        cur_we;
        txn_t        t;
        req_cycles  = 0;
        gap_pending = 0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (gap_pending) begin
                check("req_gap", {31'b0, mem_req}, 32'h0);
                gap_pending = 0;
            end
            if (!reset || !mem_req) begin
                req_cycles = 0;
            end else begin
                if (req_cycles == 0) begin
                    cur_addr = mem_addr;
                    cur_we   = mem_we;
                end else begin
                    check("req_addr_stable", mem_addr, cur_addr);
                    check("req_we_stable", {31'b0, mem_we}, {31'b0, cur_we});
                end
                req_cycles++;
                if (!hold_ack && req_cycles >= latency) begin
                    mem_ack     = 1'b1;
                    req_cycles  = 0;
                    gap_pending = 1;
                    if (exp_q.size() == 0) begin
                        check("bus_extra", 32'(exp_q.size()), 32'd1);
                    end else begin
                        t = exp_q.pop_front();
                        check("bus_we", {31'b0, mem_we}, {31'b0, t.we});
                        check("bus_addr", mem_addr, t.addr);
                        if (t.we) begin
                            check("bus_wdata", mem_wdata, t.data);
                            mem_model[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = rd_mem(mem_addr);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) if (int'(sb_count) > int'(peak)) peak = sb_count;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int unsigned n = 0;
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        while (cpu_stall && n < 50) begin n++; @(negedge clk); end
        check("store_admit", {31'b0, cpu_stall}, 32'h0);
        exp_q.push_back('{1'b1, a, d});
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic do_load_miss(input logic [31:0] a, input int pos,
                                output int unsigned stalls, output int unsigned we_cycles);
        stalls = 0; we_cycles = 0;
        cpu_re = 1'b1; cpu_addr = a;
        exp_q.insert(pos, '{1'b0, a, 32'h0});
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            if (mem_req && mem_we) we_cycles++;
            @(negedge clk);
        end
        check("miss_rdata", cpu_rdata, rd_mem(a));
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        @(negedge clk);
        while ((!sb_empty || exp_q.size() != 0 || mem_req) && n < 200) begin n++; @(negedge clk); end
        check("drain_count", {29'b0, sb_count}, 32'h0);
        check("drain_q", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int unsigned stalls, we_cycles, n, busy;
        reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_model[32'h200] = 32'h1234;
        mem_model[32'h300] = 32'h3300;
        repeat (3) @(negedge clk);
        check("rst_count", {29'b0, sb_count}, 32'h0);
        check("rst_empty", {31'b0, sb_empty}, 32'h1);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Posted stores drain in order.
        latency = 2; peak = 0;
        do_store(32'h100, 32'hA);
        do_store(32'h104, 32'hB);
        do_store(32'h100, 32'hC);
        wait_drain();
        check("s1_peak", peak, 32'd3);
        check("s1_mem100", rd_mem(32'h100), 32'hC);

        // Forwarding from buffered entries, youngest wins, low bits ignored.
        hold_ack = 1;
        do_store(32'h100, 32'hA);
        do_store(32'h104, 32'hB);
        do_store(32'h100, 32'hC);
        cpu_re = 1'b1; cpu_addr = 32'h100;
        @(negedge clk);
        check("fwd_rdata", cpu_rdata, 32'hC);
        check("fwd_stall", {31'b0, cpu_stall}, 32'h0);
        check("fwd_no_read", {31'b0, mem_req && !mem_we}, 32'h0);
        @(posedge clk); #1; cpu_addr = 32'h104;
        @(negedge clk);
        check("fwd_rdata_104", cpu_rdata, 32'hB);
        @(posedge clk); #1; cpu_addr = 32'h103;
        @(negedge clk);
        check("fwd_rdata_103", cpu_rdata, 32'hC);
        check("fwd_no_read2", {31'b0, mem_req && !mem_we}, 32'h0);
        @(posedge clk); #1; cpu_re = 1'b0; hold_ack = 0;
        wait_drain();
        check("s2_mem104", rd_mem(32'h104), 32'hB);

        // Load miss, latency 3.
        latency = 3;
        do_load_miss(32'h200, 0, stalls, we_cycles);
        check("miss_stall_cycles", stalls, 32'd4);
        check("miss_we_cycles", we_cycles, 32'd0);

        // Full buffer: fifth store admitted the cycle after the first ack.
        latency = 1; hold_ack = 1;
        for (int i = 0; i < 4; i++) do_store(32'h600 + 32'(i * 4), 32'h60 + 32'(i));
        cpu_we = 1'b1; cpu_addr = 32'h610; cpu_wdata = 32'h64;
        @(negedge clk);
        check("full_stall", {31'b0, cpu_stall}, 32'h1);
        check("full_count", {29'b0, sb_count}, 32'd4);
        @(posedge clk); #1; hold_ack = 0;
        @(negedge clk);
        check("ack_cycle_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        check("admit_stall", {31'b0, cpu_stall}, 32'h0);
        check("admit_count", {29'b0, sb_count}, 32'd3);
        exp_q.push_back('{1'b1, 32'h610, 32'h64});
        @(posedge clk); #1; cpu_we = 1'b0;
        @(negedge clk);
        check("refill_count", {29'b0, sb_count}, 32'd4);
        @(posedge clk); #1;
        wait_drain();

        // Load miss behind an in-flight write.
        latency = 2; hold_ack = 1;
        do_store(32'h400, 32'h1);
        do_store(32'h404, 32'h2);
        do_store(32'h408, 32'h3);
        n = 0;
        while (!mem_req && n < 20) begin n++; @(posedge clk); #1; end
        check("s5_write_inflight", {31'b0, mem_req && mem_we}, 32'h1);
        hold_ack = 0;
        do_load_miss(32'h300, 1, stalls, we_cycles);
        wait_drain();
        check("s5_mem408", rd_mem(32'h408), 32'h3);

        // Asynchronous reset in the middle of a write.
        hold_ack = 1;
        do_store(32'h500, 32'h5);
        do_store(32'h504, 32'h6);
        n = 0;
        while (!mem_req && n < 20) begin n++; @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("async_req", {31'b0, mem_req}, 32'h0);
        check("async_count", {29'b0, sb_count}, 32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1; hold_ack = 0;
        busy = 0;
        repeat (10) begin @(negedge clk); if (mem_req) busy++; end
        check("post_reset_idle", busy, 32'h0);
        @(posedge clk); #1;
        do_store(32'h508, 32'h7);
        wait_drain();
        check("post_reset_mem", rd_mem(32'h508), 32'h7);
        check("post_reset_nowrite", rd_mem(32'h500), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
